// File: rtl/ray_pkg.sv
// Shared definitions for the ray dispatcher and its helper blocks.
//   - object_in field slices (colour, radius, centre)
//   - bit positions of the sign flags inside the 31-bit ray direction
//   - tester "no intersection" code
//   - dispatcher state encoding
package ray_pkg;

   // object_in = {color[11:0], r[7:0], center[27:0]}
   localparam int COLOR_HI  = 47;
   localparam int COLOR_LO  = 36;
   localparam int RADIUS_HI = 35;
   localparam int RADIUS_LO = 28;
   localparam int CENTER_HI = 27;
   localparam int CENTER_LO = 0;

   // ray_dir = {sx, sy, sz, dx[9:0], dy[9:0], dz[7:0]}; sign bit set means negative
   localparam int DIR_SX = 30;
   localparam int DIR_SY = 29;
   localparam int DIR_SZ = 28;

   localparam logic [9:0] RAY_T_MISS = 10'h3FF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAST = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/ray_dir_gen.sv
// Combinational pixel-to-ray-direction encoder.
// Ports:
//   x, y  in  10  pixel column / row
//   dir   out 31  {sx, sy, sz, |x-H_RES/2|, |y-V_RES/2|, FOCAL}
// Offsets are formed as 11-bit signed values and the magnitude is
// truncated to 10 bits; sz is always 0 (rays point into the screen).
module ray_dir_gen
   import ray_pkg::*;
#(
   parameter int         H_RES = 640,
   parameter int         V_RES = 480,
   parameter logic [7:0] FOCAL = 8'd200
) (
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   output logic [30:0] dir
);

   localparam logic signed [10:0] X_CTR = 11'(H_RES / 2);
   localparam logic signed [10:0] Y_CTR = 11'(V_RES / 2);

   logic signed [10:0] diff_x;
   logic signed [10:0] diff_y;
   logic [9:0]         mag_x;
   logic [9:0]         mag_y;

   always_comb begin
      diff_x = $signed({1'b0, x}) - X_CTR;
      diff_y = $signed({1'b0, y}) - Y_CTR;
      mag_x  = diff_x[10] ? 10'(-diff_x) : diff_x[9:0];
      mag_y  = diff_y[10] ? 10'(-diff_y) : diff_y[9:0];

      dir         = '0;
      dir[DIR_SX] = diff_x[10];
      dir[DIR_SY] = diff_y[10];
      dir[DIR_SZ] = 1'b0;
      dir[27:18]  = mag_x;
      dir[17:8]   = mag_y;
      dir[7:0]    = FOCAL;
   end

endmodule

// File: rtl/ray_dispatcher.sv
// Screen sweeper for the sphere-intersection tester.
// For each pixel it walks the object table one entry per cycle, keeps the
// nearest hit reported by the combinational tester, then offers the pixel
// colour on a valid/ready port.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a frame (honoured in IDLE only)
//   eye                   ray origin, captured on an accepted start
//   obj_idx / object_in   object table address / combinational read data
//   ray_init / ray_dir    ray origin and direction to the tester
//   t_in                  tester hit distance for obj_idx (T_MISS = none)
//   pix_valid/pix_ready   pixel handshake, with pix_x/pix_y/pix_color
//   busy, frame_done      frame status; frame_done pulses once per frame
module ray_dispatcher
   import ray_pkg::*;
#(
   parameter int          H_RES    = 640,
   parameter int          V_RES    = 480,
   parameter int          N_OBJ    = 4,
   parameter logic [7:0]  FOCAL    = 8'd200,
   parameter logic [11:0] BG_COLOR = 12'h000,
   parameter logic [9:0]  T_MISS   = RAY_T_MISS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [27:0] eye,
   output logic [3:0]  obj_idx,
   input  logic [47:0] object_in,
   output logic [27:0] ray_init,
   output logic [30:0] ray_dir,
   input  logic [9:0]  t_in,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [11:0] pix_color,
   output logic        busy,
   output logic        frame_done
);

   localparam logic [3:0] LAST_OBJ = 4'(N_OBJ - 1);
   localparam logic [9:0] X_LAST   = 10'(H_RES - 1);
   localparam logic [9:0] Y_LAST   = 10'(V_RES - 1);

   state_t      state, state_nx;
   logic [9:0]  best_t;
   logic [11:0] best_color;
   logic        load_frame, accept, cast_last;
   logic        hit, last_x, last_pix;
   logic [9:0]  cand_t, nx, ny, gen_x, gen_y;
   logic [11:0] cand_color;
   logic [30:0] dir_nx;

   // Only the colour field is used here; radius/centre feed the tester.
   logic unused_obj;
   assign unused_obj = ^{object_in[RADIUS_HI:RADIUS_LO], object_in[CENTER_HI:CENTER_LO]};

   always_comb begin
      last_x   = (pix_x == X_LAST);
      last_pix = last_x && (pix_y == Y_LAST);
      nx       = last_x ? 10'd0 : pix_x + 10'd1;
      ny       = last_x ? pix_y + 10'd1 : pix_y;
      // Direction is registered for the pixel about to start, so the
      // encoder sees (0,0) when a frame is launched from IDLE.
      gen_x    = (state == IDLE) ? 10'd0 : nx;
      gen_y    = (state == IDLE) ? 10'd0 : ny;

      // Strictly-less keeps the lower object index on a tie.
      hit        = (t_in != T_MISS) && (t_in < best_t);
      cand_t     = hit ? t_in : best_t;
      cand_color = hit ? object_in[COLOR_HI:COLOR_LO] : best_color;
   end

   ray_dir_gen #(
      .H_RES (H_RES),
      .V_RES (V_RES),
      .FOCAL (FOCAL)
   ) u_dir_gen (
      .x   (gen_x),
      .y   (gen_y),
      .dir (dir_nx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      load_frame = 1'b0;
      accept     = 1'b0;
      cast_last  = 1'b0;
      case (state)
         IDLE: if (start) begin
            load_frame = 1'b1;
            state_nx   = CAST;
         end
         CAST: if (obj_idx == LAST_OBJ) begin
            cast_last = 1'b1;
            state_nx  = EMIT;
         end
         // pix_valid is always high in EMIT, so ready alone is an accept.
         EMIT: if (pix_ready) begin
            accept   = 1'b1;
            state_nx = last_pix ? DONE : CAST;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         obj_idx    <= '0;
         ray_init   <= '0;
         ray_dir    <= '0;
         pix_valid  <= 1'b0;
         pix_x      <= '0;
         pix_y      <= '0;
         pix_color  <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         best_t     <= T_MISS;
         best_color <= BG_COLOR;
      end else begin
         frame_done <= 1'b0;

         if (load_frame) begin
            ray_init   <= eye;
            ray_dir    <= dir_nx;
            pix_x      <= '0;
            pix_y      <= '0;
            obj_idx    <= '0;
            best_t     <= T_MISS;
            best_color <= BG_COLOR;
            busy       <= 1'b1;
         end

         if (state == CAST) begin
            best_t     <= cand_t;
            best_color <= cand_color;
            obj_idx    <= obj_idx + 4'd1;
            if (cast_last) begin
               pix_color <= cand_color;
               pix_valid <= 1'b1;
            end
         end

         if (accept) begin
            pix_valid  <= 1'b0;
            obj_idx    <= '0;
            best_t     <= T_MISS;
            best_color <= BG_COLOR;
            if (last_pix) begin
               busy       <= 1'b0;
               frame_done <= 1'b1;
            end else begin
               pix_x   <= nx;
               pix_y   <= ny;
               ray_dir <= dir_nx;
            end
         end
      end
   end

endmodule

// File: doc/ray_dispatcher.md
Name: ray_dispatcher

Overview:
- Pixel-side end of the sphere-intersection interface: sweeps the screen, drives ray origin and direction plus an object index into the combinational sphere tester, and consumes the returned hit distance.
- Runs over the object table one object per cycle, keeps the nearest hit, and emits one 12-bit colour per pixel to the framebuffer writer over a valid/ready handshake.
- Sits between the object table ROM/RAM and the framebuffer write port.

Parameters:
- H_RES, 640, pixels per line (max 1023)
- V_RES, 480, lines per frame (max 1023)
- N_OBJ, 4, objects in table (1..16)
- FOCAL, 8'd200, z magnitude of every ray direction
- BG_COLOR, 12'h000, colour emitted on miss
- T_MISS, 10'h3FF, tester code meaning "no intersection"

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin frame
- eye  in  28  ray origin {x[9:0], y[9:0], z[7:0]}; sampled on accepted start
- obj_idx  out  4  object table read address
- object_in  in  48  {color[11:0], r[7:0], center[27:0]}; combinational read of obj_idx
- ray_init  out  28  origin to tester (registered copy of eye)
- ray_dir  out  31  {sx, sy, sz, dx[9:0], dy[9:0], dz[7:0]}; s* = 1 means negative
- t_in  in  10  tester result for current obj_idx, same cycle
- pix_valid  out  1  pixel colour available
- pix_ready  in  1  framebuffer accepts
- pix_x  out  10  pixel column
- pix_y  out  10  pixel row
- pix_color  out  12  pixel colour
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last pixel accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE; obj_idx=0, ray_init=0, ray_dir=0, pix_valid=0, pix_x=0, pix_y=0, pix_color=0, busy=0, frame_done=0, best_t=T_MISS. Reset mid-frame abandons the frame with no further pixel output.
- States: IDLE, CAST, EMIT, DONE.
- IDLE
  - start=1: latch eye into ray_init, set pix_x=0, pix_y=0, obj_idx=0, best_t=T_MISS, best_color=BG_COLOR, busy=1, go to CAST.
  - start is ignored in every other state.
- Direction: registered from pix_x/pix_y at pixel start.
  - dx = |pix_x - H_RES/2|, sx = (pix_x < H_RES/2).
  - dy = |pix_y - V_RES/2|, sy = (pix_y < V_RES/2).
  - dz = FOCAL, sz = 0.
  - Differences are computed 11-bit signed, magnitude truncated to 10 bits. ray_dir is stable for the whole pixel.
- CAST: one object per cycle.
  - If t_in != T_MISS and t_in < best_t (strictly less), best_t <= t_in and best_color <= object_in[47:36]. Ties keep the lower index.
  - obj_idx increments each cycle. After obj_idx == N_OBJ-1 is evaluated: pix_color <= best_color, pix_valid <= 1, go to EMIT.
  - Latency: N_OBJ cycles from pixel start to pix_valid.
- EMIT
  - pix_valid, pix_x, pix_y and pix_color hold until pix_valid & pix_ready.
  - On accept: pix_valid <= 0; reset obj_idx, best_t and best_color; advance the pixel.
    - pix_x wraps at H_RES-1 to 0 and increments pix_y.
    - Last pixel (H_RES-1, V_RES-1) goes to DONE; otherwise go to CAST.
  - pix_ready=1 in the same cycle pix_valid rises counts as an accept. Throughput is N_OBJ+1 cycles per pixel with pix_ready held high.
- DONE: frame_done=1 for exactly one cycle, busy=0, go to IDLE. A start arriving in DONE is ignored.
- Arithmetic is unsigned except the centre offsets; t comparison is unsigned 10-bit.

Decomposition:
- Shared package ray_pkg holds:
  - field slices for object_in: COLOR, RADIUS, CENTER
  - dir sign-bit positions
  - T_MISS
  - state enum
- Sub-module ray_dir_gen: combinational pixel-to-{sign, magnitude} direction encoder. It is reused by later shading blocks.

Test Plan:
- Reset mid-CAST at pixel (5,0): assert rst_n=0 -> all outputs 0 and busy=0 next edge; no pix_valid until a new start.
- H_RES=4, V_RES=2, N_OBJ=2, tester stub t_in=T_MISS always, pix_ready=1 -> 8 pixels, all colour BG_COLOR, order (0,0)..(3,1), frame_done pulses once; total 8*3 + 2 cycles.
- Nearest hit: obj0 t=50 colour 12'hF00, obj1 t=20 colour 12'h0F0 -> pix_color=12'h0F0.
- Tie: both t=30, colours 12'hF00 and 12'h00F -> pix_color=12'hF00.
- Backpressure: pix_ready low 5 cycles at pixel (1,0) -> pix_valid, pix_x=1 and pix_color stable all 5 cycles; exactly one accept.
- Direction check at H_RES=640, V_RES=480: pixel (0,0) -> ray_dir = {1,1,0,10'd320,10'd240,8'd200}; pixel (400,300) -> {0,0,0,10'd80,10'd60,8'd200}.
